pipe_stage_tracker: RTL and testbench

- Tracks the two pipeline stages downstream of decode/read: s2 (execute) and s3 (memory/writeback).
- Produces the s2_*/s3_* hazard-status signals consumed by decode/read.
- Produces operand forwarding selects for the instruction currently in decode, the register-file writeback strobe, and a retired-instruction counter.
- Sits between decode/read and the datapath control muxes; it is the producer side of the decode hazard interface.

---
 rtl/pipe_stage_tracker_pkg.sv | 51 +++++
 rtl/pipe_stage_tracker_fwd_select.sv | 35 +++
 rtl/pipe_stage_tracker.sv | 109 ++++++++++
 tb/tb_pipe_stage_tracker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_tracker_pkg.sv
// Shared types for the s2/s3 stage tracker: stage records,
// the bubble constant and the operand forwarding encodings.
package pipe_stage_tracker_pkg;

  typedef struct packed {
    logic       valid;
    logic       reg_we;
    logic       mem_rr;
    logic       mem_we;
    logic [4:0] rd;
  } stage_t;

  localparam stage_t BUBBLE = '{
    valid:  1'b0,
    reg_we: 1'b0,
    mem_rr: 1'b0,
    mem_we: 1'b0,
    rd:     5'd0
  };

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_S2  = 2'b01;
  localparam logic [1:0] FWD_S3  = 2'b10;
  localparam logic [1:0] FWD_HAZ = 2'b11;

  // Flags gated by valid; a write to x0 is reported as no write.
  function automatic stage_t stage_view(input stage_t s);
    stage_t v;
    v        = s;
    v.reg_we = s.valid & s.reg_we & (s.rd != 5'd0);
    v.mem_rr = s.valid & s.mem_rr;
    v.mem_we = s.valid & s.mem_we;
    return v;
  endfunction

  function automatic stage_t decode_entry(
    input logic       reg_we,
    input logic       mem_rr,
    input logic       mem_we,
    input logic [4:0] rd
  );
    stage_t e;
    e.valid  = 1'b1;
    e.reg_we = reg_we;
    e.mem_rr = mem_rr;
    e.mem_we = mem_we;
    e.rd     = rd;
    return e;
  endfunction

endpackage

// File: rtl/pipe_stage_tracker_fwd_select.sv
// Forwarding source select for one decode source operand.
// Expects stage records already normalised by stage_view.
module fwd_select
  import pipe_stage_tracker_pkg::*;
(
  input  logic [4:0] i_rs,
  input  stage_t     i_s2,
  input  stage_t     i_s3,
  output logic [1:0] o_sel
);

  logic w_rs_nz;
  logic w_s2_hit;
  logic w_s3_hit;
  logic w_unused;

  assign w_rs_nz  = (i_rs != 5'd0);
  assign w_s2_hit = w_rs_nz & i_s2.valid
                  & i_s2.reg_we & (i_s2.rd == i_rs);
  assign w_s3_hit = w_rs_nz & i_s3.valid
                  & i_s3.reg_we & (i_s3.rd == i_rs);
  assign w_unused = ^{i_s2.mem_we, i_s3.mem_rr,
                      i_s3.mem_we};

  // Youngest producer wins; a load in s2 cannot be forwarded yet.
  always_comb begin
    o_sel = FWD_RF;
    if (w_s2_hit) begin
      o_sel = i_s2.mem_rr ? FWD_HAZ : FWD_S2;
    end else if (w_s3_hit) begin
      o_sel = FWD_S3;
    end
  end

endmodule

// File: rtl/pipe_stage_tracker.sv
// Tracks the execute (s2) and memory/writeback (s3) stages and
// produces hazard status, forwarding selects, writeback and instret.
module pipe_stage_tracker
  import pipe_stage_tracker_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             d_valid,
  input  logic             read_bubble,
  input  logic             d_reg_we,
  input  logic             d_mem_we,
  input  logic             d_mem_rr,
  input  logic [4:0]       d_rd,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  output logic             s2_valid,
  output logic             s2_reg_we,
  output logic             s2_mem_rr,
  output logic             s2_mem_we,
  output logic [4:0]       s2_rd,
  output logic             s3_valid,
  output logic             s3_reg_we,
  output logic             s3_mem_rr,
  output logic [4:0]       s3_rd,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] instret
);

  stage_t           r_s2;
  stage_t           r_s3;
  logic [CNT_W-1:0] r_instret;

  stage_t w_s2_next;
  stage_t w_s2_view;
  stage_t w_s3_view;
  logic   w_squash;
  logic   w_retire;

  assign w_squash = flush | read_bubble | ~d_valid;
  assign w_retire = r_s3.valid & ~stall;

  always_comb begin
    w_s2_next = BUBBLE;
    if (!w_squash) begin
      w_s2_next = decode_entry(d_reg_we, d_mem_rr,
                               d_mem_we, d_rd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2 <= BUBBLE;
      r_s3 <= BUBBLE;
    end else if (!stall) begin
      r_s2 <= w_s2_next;
      r_s3 <= r_s2;
    end
  end

  // Free-running count; wraps without saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign w_s2_view = stage_view(r_s2);
  assign w_s3_view = stage_view(r_s3);

  assign s2_valid  = w_s2_view.valid;
  assign s2_reg_we = w_s2_view.reg_we;
  assign s2_mem_rr = w_s2_view.mem_rr;
  assign s2_mem_we = w_s2_view.mem_we;
  assign s2_rd     = w_s2_view.rd;

  assign s3_valid  = w_s3_view.valid;
  assign s3_reg_we = w_s3_view.reg_we;
  assign s3_mem_rr = w_s3_view.mem_rr;
  assign s3_rd     = w_s3_view.rd;

  // Held off during stall so each retirement writes exactly once.
  assign wb_we   = w_s3_view.reg_we & ~stall;
  assign wb_rd   = r_s3.rd;
  assign instret = r_instret;

  fwd_select u_fwd_a (
    .i_rs  (d_rs1),
    .i_s2  (w_s2_view),
    .i_s3  (w_s3_view),
    .o_sel (fwd_a_sel)
  );

  fwd_select u_fwd_b (
    .i_rs  (d_rs2),
    .i_s2  (w_s2_view),
    .i_s3  (w_s3_view),
    .o_sel (fwd_b_sel)
  );

endmodule

// File: tb/tb_pipe_stage_tracker.sv
// Self-checking bench for pipe_stage_tracker: directed table,
// counter wrap, async reset and randomized model comparison.
module tb_pipe_stage_tracker;

  localparam int CW = 4;

  logic          clk, rst, stall, flush;
  logic          d_valid, read_bubble;
  logic          d_reg_we, d_mem_we, d_mem_rr;
  logic [4:0]    d_rd, d_rs1, d_rs2;
  logic          s2_valid, s2_reg_we, s2_mem_rr, s2_mem_we;
  logic [4:0]    s2_rd;
  logic          s3_valid, s3_reg_we, s3_mem_rr;
  logic [4:0]    s3_rd;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [CW-1:0] instret;

  int checks = 0;
  int errors = 0;

  pipe_stage_tracker #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .d_valid(d_valid), .read_bubble(read_bubble),
    .d_reg_we(d_reg_we), .d_mem_we(d_mem_we),
    .d_mem_rr(d_mem_rr), .d_rd(d_rd),
    .d_rs1(d_rs1), .d_rs2(d_rs2),
    .s2_valid(s2_valid), .s2_reg_we(s2_reg_we),
    .s2_mem_rr(s2_mem_rr), .s2_mem_we(s2_mem_we),
    .s2_rd(s2_rd), .s3_valid(s3_valid),
    .s3_reg_we(s3_reg_we), .s3_mem_rr(s3_mem_rr),
    .s3_rd(s3_rd), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .wb_we(wb_we),
    .wb_rd(wb_rd), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Directed vectors: inputs for the cycle, outputs seen before the edge.
  typedef struct {
    logic st, fl, dv, rb, we, rr, sw;
    logic [4:0] rd, r1, r2;
    logic s2v, s2we;
    logic [4:0] s2rd;
    logic s3v;
    logic [4:0] s3rd;
    logic [1:0] fa, fb;
    logic wb;
    logic [CW-1:0] ir;
  } vec_t;

  function automatic vec_t mk(
    int st, int fl, int dv, int rb, int we, int rr, int sw,
    int rd, int r1, int r2,
    int s2v, int s2we, int s2rd, int s3v, int s3rd,
    int fa, int fb, int wb, int ir);
    vec_t x;
    x.st = st[0]; x.fl = fl[0]; x.dv = dv[0]; x.rb = rb[0];
    x.we = we[0]; x.rr = rr[0]; x.sw = sw[0];
    x.rd = rd[4:0]; x.r1 = r1[4:0]; x.r2 = r2[4:0];
    x.s2v = s2v[0]; x.s2we = s2we[0]; x.s2rd = s2rd[4:0];
    x.s3v = s3v[0]; x.s3rd = s3rd[4:0];
    x.fa = fa[1:0]; x.fb = fb[1:0]; x.wb = wb[0];
    x.ir = ir[CW-1:0];
    return x;
  endfunction

  vec_t tbl[18];

  // Reference model: two slots of plain records.
  typedef struct {
    bit v, we, rr, sw;
    int rd;
  } m_t;

  m_t ms2, ms3;
  int m_ir;

  function automatic bit m_writes(m_t s);
    return s.v && s.we && s.rd != 0;
  endfunction

  function automatic int m_fwd(int rs);
    if (rs == 0) return 0;
    if (m_writes(ms2) && ms2.rd == rs) return ms2.rr ? 3 : 1;
    if (m_writes(ms3) && ms3.rd == rs) return 2;
    return 0;
  endfunction

  function automatic m_t m_empty();
    m_t e;
    e.v = 0; e.we = 0; e.rr = 0; e.sw = 0; e.rd = 0;
    return e;
  endfunction

  task automatic m_clock();
    m_t n;
    if (!stall) begin
      if (ms3.v) m_ir = (m_ir + 1) % (1 << CW);
      ms3 = ms2;
      if (flush || read_bubble || !d_valid) begin
        ms2 = m_empty();
      end else begin
        n.v = 1; n.we = d_reg_we; n.rr = d_mem_rr;
        n.sw = d_mem_we; n.rd = int'(d_rd);
        ms2 = n;
      end
    end
  endtask

  task automatic m_compare();
    chk("r_s2_valid", s2_valid, ms2.v);
    chk("r_s2_reg_we", s2_reg_we, m_writes(ms2));
    chk("r_s2_mem_rr", s2_mem_rr, ms2.v && ms2.rr);
    chk("r_s2_mem_we", s2_mem_we, ms2.v && ms2.sw);
    chk("r_s2_rd", s2_rd, ms2.rd);
    chk("r_s3_valid", s3_valid, ms3.v);
    chk("r_s3_reg_we", s3_reg_we, m_writes(ms3));
    chk("r_s3_mem_rr", s3_mem_rr, ms3.v && ms3.rr);
    chk("r_s3_rd", s3_rd, ms3.rd);
    chk("r_fwd_a", fwd_a_sel, m_fwd(int'(d_rs1)));
    chk("r_fwd_b", fwd_b_sel, m_fwd(int'(d_rs2)));
    chk("r_wb_we", wb_we, m_writes(ms3) && !stall);
    if (m_writes(ms3)) chk("r_wb_rd", wb_rd, ms3.rd);
    chk("r_instret", instret, m_ir);
  endtask

  task automatic set_in(vec_t x);
    stall = x.st; flush = x.fl; d_valid = x.dv;
    read_bubble = x.rb; d_reg_we = x.we;
    d_mem_rr = x.rr; d_mem_we = x.sw;
    d_rd = x.rd; d_rs1 = x.r1; d_rs2 = x.r2;
  endtask

  initial begin
    //             st fl dv rb we rr sw rd r1 r2 | s2v we rd s3v rd fa fb wb ir
    tbl[0]  = mk(0,0,1,0,1,0,0, 5,0,0, 0,0,0, 0,0, 0,0,0,0);
    tbl[1]  = mk(0,0,1,0,1,0,0, 6,5,1, 1,1,5, 0,0, 1,0,0,0);
    tbl[2]  = mk(0,0,1,0,1,0,0, 8,5,6, 1,1,6, 1,5, 2,1,1,0);
    tbl[3]  = mk(0,0,1,0,1,1,0, 7,0,8, 1,1,8, 1,6, 0,1,1,1);
    tbl[4]  = mk(0,0,1,1,1,0,0,10,0,7, 1,1,7, 1,8, 0,3,1,2);
    tbl[5]  = mk(0,0,1,0,1,0,0,10,0,7, 0,0,0, 1,7, 0,2,1,3);
    tbl[6]  = mk(0,0,0,0,0,0,0, 0,0,0, 1,1,10,0,0, 0,0,0,4);
    tbl[7]  = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 1,10,0,0,1,4);
    tbl[8]  = mk(0,0,1,0,1,0,0, 9,0,0, 0,0,0, 0,0, 0,0,0,5);
    tbl[9]  = mk(0,1,1,0,1,0,0,11,0,0, 1,1,9, 0,0, 0,0,0,5);
    tbl[10] = mk(1,0,0,0,0,0,0, 0,0,0, 0,0,0, 1,9, 0,0,0,5);
    tbl[11] = mk(1,1,1,0,1,0,0,12,9,0, 0,0,0, 1,9, 2,0,0,5);
    tbl[12] = mk(1,1,1,0,1,0,0,12,9,0, 0,0,0, 1,9, 2,0,0,5);
    tbl[13] = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 1,9, 0,0,1,5);
    tbl[14] = mk(0,0,1,0,1,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,6);
    tbl[15] = mk(0,0,0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 0,0,0,6);
    tbl[16] = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 1,0, 0,0,0,6);
    tbl[17] = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,7);

    rst = 1'b1;
    set_in(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    #2;
    chk("rst_s2_valid", s2_valid, 0);
    chk("rst_s3_valid", s3_valid, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_instret", instret, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i]);
      #1;
      chk($sformatf("t%0d_s2_valid", i), s2_valid, tbl[i].s2v);
      chk($sformatf("t%0d_s2_reg_we", i), s2_reg_we, tbl[i].s2we);
      chk($sformatf("t%0d_s2_rd", i), s2_rd, tbl[i].s2rd);
      chk($sformatf("t%0d_s3_valid", i), s3_valid, tbl[i].s3v);
      chk($sformatf("t%0d_s3_rd", i), s3_rd, tbl[i].s3rd);
      chk($sformatf("t%0d_fwd_a", i), fwd_a_sel, tbl[i].fa);
      chk($sformatf("t%0d_fwd_b", i), fwd_b_sel, tbl[i].fb);
      chk($sformatf("t%0d_wb_we", i), wb_we, tbl[i].wb);
      if (tbl[i].wb)
        chk($sformatf("t%0d_wb_rd", i), wb_rd, tbl[i].s3rd);
      chk($sformatf("t%0d_instret", i), instret, tbl[i].ir);
      @(posedge clk);
      #1;
    end

    // Nine stores retire: 7 + 9 wraps to 0 in a 4-bit counter.
    for (int i = 0; i < 11; i++) begin
      if (i < 9) set_in(mk(0,0,1,0,0,0,1,3,0,0,0,0,0,0,0,0,0,0,0));
      else set_in(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      #1;
      chk($sformatf("store%0d_wb_we", i), wb_we, 0);
      @(posedge clk);
      #1;
    end
    chk("wrap_instret", instret, 0);
    chk("wrap_s3_valid", s3_valid, 0);

    ms2 = m_empty();
    ms3 = m_empty();
    m_ir = 0;
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      read_bubble = ($urandom_range(0, 5) == 0);
      d_valid     = ($urandom_range(0, 3) != 0);
      d_reg_we    = $urandom_range(0, 1) == 1;
      d_mem_rr    = $urandom_range(0, 2) == 0;
      d_mem_we    = $urandom_range(0, 3) == 0;
      d_rd        = 5'($urandom_range(0, 7));
      d_rs1       = 5'($urandom_range(0, 7));
      d_rs2       = 5'($urandom_range(0, 7));
      #1;
      m_compare();
      if (c == 200) begin
        // Reset between edges with state in flight.
        d_rs1 = 5'd0;
        #1 rst = 1'b1;
        #1;
        chk("arst_s2_valid", s2_valid, 0);
        chk("arst_s3_valid", s3_valid, 0);
        chk("arst_s3_reg_we", s3_reg_we, 0);
        chk("arst_s2_rd", s2_rd, 0);
        chk("arst_wb_we", wb_we, 0);
        chk("arst_fwd_b", fwd_b_sel, 0);
        chk("arst_instret", instret, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        ms2 = m_empty();
        ms3 = m_empty();
        m_ir = 0;
      end else begin
        @(posedge clk);
        m_clock();
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
